// File: rtl/tty_pkg.sv
`default_nettype none
// ============================================================================
// tty_pkg : shared types and constants for the TTY write arbiter
// Revision: 1.0
// ============================================================================
package tty_pkg;

  localparam int DATA_W            = 8;
  localparam int KEY_DEPTH_DEFAULT = 8;

  // Bit positions inside the CPU-visible status byte
  localparam int ST_KEY     = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_KBOVF   = 2;
  localparam int ST_CPUOVF  = 3;
  localparam int ST_ECHOOVF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU  = 1'b0,
    ECHO = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/tty_key_fifo.sv
`default_nettype none
// ============================================================================
// tty_key_fifo : key-code FIFO; a push while full is kept only if a pop
//                happens in the same cycle. Revision: 1.0
// ============================================================================
module tty_key_fifo
  import tty_pkg::*;
#(
  parameter int DEPTH = KEY_DEPTH_DEFAULT,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Power-of-two depth lets the pointers wrap on their own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/tty_write_arbiter.sv
`default_nettype none
// ============================================================================
// tty_write_arbiter : round-robin sharing of the VGA character write port
//                     between CPU writes and keyboard echo. Revision: 1.0
// ============================================================================
module tty_write_arbiter
  import tty_pkg::*;
#(
  parameter int KEY_DEPTH = KEY_DEPTH_DEFAULT,
  parameter int WR_GAP    = 3
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_rd,
  input  logic       cpu_rsel,
  output logic [7:0] cpu_rdata,
  output logic       cpu_busy,
  input  logic       kb_valid,
  input  logic [7:0] kb_ascii,
  input  logic       echo_en,
  output logic       vm_write,
  output logic [7:0] vm_data,
  output logic       key_irq
);

  localparam int GAP_W = (WR_GAP <= 1) ? 1 : $clog2(WR_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

  arb_state_t       state;
  grant_t           grant;
  grant_t           last_grant;
  grant_t           next_grant;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0] cpu_hold;
  logic [7:0] echo_hold;
  logic       echo_full;
  logic       cpu_ovf;
  logic       kb_ovf;
  logic       echo_ovf;
  logic [7:0] status;

  logic       cpu_load;
  logic       cpu_drop;
  logic       echo_load;
  logic       echo_drop;
  logic       issue_cpu;
  logic       issue_echo;
  logic       key_rd;
  logic       stat_rd;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       kb_drop;

  assign cpu_load   = cpu_wr & ~cpu_busy;
  assign cpu_drop   = cpu_wr & cpu_busy;
  assign echo_load  = kb_valid & echo_en & ~echo_full;
  assign echo_drop  = kb_valid & echo_en & echo_full;
  assign issue_cpu  = (state == ISSUE) && (grant == CPU);
  assign issue_echo = (state == ISSUE) && (grant == ECHO);
  assign key_rd     = cpu_rd & ~cpu_rsel;
  assign stat_rd    = cpu_rd & cpu_rsel;
  assign key_irq    = ~fifo_empty;

  tty_key_fifo #(
    .DEPTH (KEY_DEPTH),
    .WIDTH (DATA_W)
  ) u_key_fifo (
    .clk       (clk_50mhz),
    .rst_n     (rst_n),
    .push      (kb_valid),
    .push_data (kb_ascii),
    .pop       (key_rd),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (kb_drop)
  );

  always_comb begin
    status             = 8'h00;
    status[ST_KEY]     = key_irq;
    status[ST_BUSY]    = cpu_busy;
    status[ST_KBOVF]   = kb_ovf;
    status[ST_CPUOVF]  = cpu_ovf;
    status[ST_ECHOOVF] = echo_ovf;
  end

  always_comb begin
    next_grant = CPU;
    if (cpu_busy && echo_full)
      next_grant = (last_grant == CPU) ? ECHO : CPU;
    else if (echo_full)
      next_grant = ECHO;
  end

  // A held entry is freed only by its own ISSUE cycle, so loads never collide with frees
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold  <= 8'h00;
      cpu_busy  <= 1'b0;
      echo_hold <= 8'h00;
      echo_full <= 1'b0;
    end else begin
      if (cpu_load) begin
        cpu_hold <= cpu_wdata;
        cpu_busy <= 1'b1;
      end else if (issue_cpu) begin
        cpu_busy <= 1'b0;
      end
      if (echo_load) begin
        echo_hold <= kb_ascii;
        echo_full <= 1'b1;
      end else if (issue_echo) begin
        echo_full <= 1'b0;
      end
    end
  end

  // Overflow events take priority over the clear-on-read of the status byte
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ovf   <= 1'b0;
      kb_ovf    <= 1'b0;
      echo_ovf  <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      cpu_ovf  <= cpu_drop  | (cpu_ovf  & ~stat_rd);
      kb_ovf   <= kb_drop   | (kb_ovf   & ~stat_rd);
      echo_ovf <= echo_drop | (echo_ovf & ~stat_rd);
      if (key_rd)
        cpu_rdata <= fifo_empty ? 8'h00 : fifo_head;
      else if (stat_rd)
        cpu_rdata <= status;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= CPU;
      last_grant <= ECHO;
      gap_cnt    <= '0;
      vm_write   <= 1'b0;
      vm_data    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_busy || echo_full) begin
            grant    <= next_grant;
            vm_data  <= (next_grant == CPU) ? cpu_hold : echo_hold;
            vm_write <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          vm_write   <= 1'b0;
          last_grant <= grant;
          gap_cnt    <= '0;
          state      <= (WR_GAP > 0) ? GAP : IDLE;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          vm_write <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tty_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tty_write_arbiter : self-checking bench for tty_write_arbiter
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tty_write_arbiter;

  localparam int KEY_DEPTH = 8;
  localparam int WR_GAP    = 3;

  logic       clk_50mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cpu_wr    = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_rd    = 1'b0;
  logic       cpu_rsel  = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_busy;
  logic       kb_valid  = 1'b0;
  logic [7:0] kb_ascii  = 8'h00;
  logic       echo_en   = 1'b0;
  logic       vm_write;
  logic [7:0] vm_data;
  logic       key_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       sel;
    logic [7:0] rdata;
    logic       irq;
  } rd_vec_t;

  rd_vec_t tbl [10];

  tty_write_arbiter #(
    .KEY_DEPTH (KEY_DEPTH),
    .WR_GAP    (WR_GAP)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_rsel  (cpu_rsel),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .kb_valid  (kb_valid),
    .kb_ascii  (kb_ascii),
    .echo_en   (echo_en),
    .vm_write  (vm_write),
    .vm_data   (vm_data),
    .key_irq   (key_irq)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz) cyc++;

  // Every display write must match the oldest expected character
  always @(negedge clk_50mhz) begin
    logic [7:0] exp_d;
    if (vm_write === 1'b1) begin
      wr_count++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL vm_write_unexpected: got data 0x%02h, required no write", vm_data);
      end else begin
        exp_d = sb.pop_front();
        if (vm_data !== exp_d) begin
          errors++;
          $display("FAIL vm_data: got 0x%02h, required 0x%02h", vm_data, exp_d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic do_reset();
    cpu_wr = 0; cpu_rd = 0; cpu_rsel = 0; kb_valid = 0; echo_en = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic cpu_write(input logic [7:0] d);
    cpu_wr = 1; cpu_wdata = d;
    tick();
    cpu_wr = 0;
  endtask

  task automatic kb_key(input logic [7:0] d);
    kb_valid = 1; kb_ascii = d;
    tick();
    kb_valid = 0;
  endtask

  task automatic do_read(input logic sel, output logic [7:0] v);
    cpu_rd = 1; cpu_rsel = sel;
    tick();
    cpu_rd = 0; cpu_rsel = 0;
    v = cpu_rdata;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_writes", wr_count, target);
  endtask

  task automatic run_table(input string name, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      do_read(tbl[i].sel, v);
      check($sformatf("%s_rdata%0d", name, i), v, tbl[i].rdata);
      check($sformatf("%s_irq%0d", name, i), key_irq, tbl[i].irq);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int base;

    // Reset values
    do_reset();
    check("rst_vm_write", vm_write, 0);
    check("rst_vm_data", vm_data, 8'h00);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_busy", cpu_busy, 0);
    check("rst_irq", key_irq, 0);

    // Single CPU write: pulse two cycles after the strobe
    base = wr_count;
    sb.push_back(8'h41);
    cpu_write(8'h41);
    check("t1_busy_c1", cpu_busy, 1);
    check("t1_vmw_c1", vm_write, 0);
    tick();
    check("t1_busy_c2", cpu_busy, 1);
    check("t1_vmw_c2", vm_write, 1);
    check("t1_vmdata", vm_data, 8'h41);
    tick();
    check("t1_busy_c3", cpu_busy, 0);
    check("t1_vmw_c3", vm_write, 0);
    repeat (12) tick();
    check("t1_one_pulse", wr_count - base, 1);

    // Tie after reset: CPU first, echo WR_GAP+2 cycles later
    do_reset();
    base = wr_count;
    echo_en = 1;
    sb.push_back(8'h42);
    sb.push_back(8'h61);
    cpu_wr = 1; cpu_wdata = 8'h42; kb_valid = 1; kb_ascii = 8'h61;
    tick();
    cpu_wr = 0; kb_valid = 0;
    wait_writes(base + 2, 30);
    check("t2_spacing", last_wr_cyc - prev_wr_cyc, WR_GAP + 2);
    check("t2_irq", key_irq, 1);
    do_read(0, v);
    check("t2_fifo", v, 8'h61);

    // Round robin: after a CPU grant, a tie goes to the echo first
    do_reset();
    base = wr_count;
    echo_en = 1;
    sb.push_back(8'h50);
    cpu_write(8'h50);
    wait_writes(base + 1, 10);
    repeat (6) tick();
    sb.push_back(8'h71);
    sb.push_back(8'h51);
    cpu_wr = 1; cpu_wdata = 8'h51; kb_valid = 1; kb_ascii = 8'h71;
    tick();
    cpu_wr = 0; kb_valid = 0;
    wait_writes(base + 3, 30);
    check("t2b_spacing", last_wr_cyc - prev_wr_cyc, WR_GAP + 2);

    // Nine keys into an eight-deep FIFO, echo disabled
    do_reset();
    for (int i = 0; i < 9; i++) kb_key(8'(8'h30 + i));
    do_read(1, v);
    check("t3_status", v, 8'h05);
    repeat (3) tick();
    check("t3_rdata_hold", cpu_rdata, 8'h05);
    for (int i = 0; i < 8; i++) begin
      tbl[i].sel = 1'b0; tbl[i].rdata = 8'(8'h30 + i); tbl[i].irq = (i < 7);
    end
    tbl[8].sel = 1'b0; tbl[8].rdata = 8'h00; tbl[8].irq = 1'b0;
    tbl[9].sel = 1'b1; tbl[9].rdata = 8'h00; tbl[9].irq = 1'b0;
    run_table("t3", 10);

    // Back-to-back CPU writes: second is dropped and flagged
    do_reset();
    base = wr_count;
    sb.push_back(8'h10);
    cpu_write(8'h10);
    cpu_write(8'h11);
    do_read(1, v);
    check("t4_status_pending", v, 8'h0A);
    wait_writes(base + 1, 10);
    repeat (8) tick();
    check("t4_one_write", wr_count - base, 1);
    do_read(1, v);
    check("t4_status_clear", v, 8'h00);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 8; i++) kb_key(8'(8'h40 + i));
    cpu_rd = 1; cpu_rsel = 0; kb_valid = 1; kb_ascii = 8'h7A;
    tick();
    cpu_rd = 0; kb_valid = 0;
    check("t5_old_head", cpu_rdata, 8'h40);
    do_read(1, v);
    check("t5_no_kbovf", v, 8'h01);
    for (int i = 0; i < 7; i++) begin
      tbl[i].sel = 1'b0; tbl[i].rdata = 8'(8'h41 + i); tbl[i].irq = 1'b1;
    end
    tbl[7].sel = 1'b0; tbl[7].rdata = 8'h7A; tbl[7].irq = 1'b0;
    tbl[8].sel = 1'b0; tbl[8].rdata = 8'h00; tbl[8].irq = 1'b0;
    run_table("t5", 9);

    // Echo overflow, and an echo held past echo_en falling
    do_reset();
    base = wr_count;
    echo_en = 1;
    sb.push_back(8'h61);
    kb_key(8'h61);
    kb_key(8'h62);
    do_read(1, v);
    check("t7_status", v, 8'h11);
    wait_writes(base + 1, 10);
    repeat (8) tick();
    sb.push_back(8'h63);
    kb_key(8'h63);
    echo_en = 0;
    wait_writes(base + 2, 10);
    repeat (8) tick();
    check("t7_writes", wr_count - base, 2);

    // Reset asserted during the ISSUE cycle
    do_reset();
    base = wr_count;
    kb_key(8'h20);
    do_read(1, v);
    check("t6_pre_status", v, 8'h01);
    cpu_write(8'h55);
    tick();
    check("t6_issue", vm_write, 1);
    #2;
    rst_n = 0;
    #1;
    check("t6_async_drop", vm_write, 0);
    tick();
    rst_n = 1;
    tick();
    check("t6_vm_data", vm_data, 8'h00);
    check("t6_rdata", cpu_rdata, 8'h00);
    check("t6_busy", cpu_busy, 0);
    check("t6_irq", key_irq, 0);
    repeat (12) tick();
    check("t6_no_replay", wr_count - base, 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
